// File: rtl/fp8_pkg.sv
// Shared definitions for the FP8 arithmetic blocks:
// field layout, bias, saturation/flush codes and divider FSM states.
package fp8_pkg;

    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 4;
    localparam int MANT_W   = 4;
    localparam int EXP_W    = 3;
    localparam int EXP_BIAS = 3;
    localparam int EXP_MAX  = 7;

    // Mantissa with hidden one, remainder with one guard bit.
    localparam int MA_W    = MANT_W + 1;
    localparam int REM_W   = MANT_W + 2;
    // Signed exponent difference, wide enough for -5..10.
    localparam int EDIFF_W = 5;
    localparam int CNT_W   = 3;

    // Magnitude fields (exponent and mantissa) for clamped results.
    localparam logic [6:0] FP8_SAT_MAG   = 7'h7F;
    localparam logic [6:0] FP8_FLUSH_MAG = 7'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    // Mantissa with the implicit leading one restored.
    function automatic logic [MA_W-1:0] fp8_mant(
        input logic [7:0] x
    );
        return {1'b1, x[MANT_W-1:0]};
    endfunction

    // Assemble an FP8 word from its fields.
    function automatic logic [7:0] fp8_pack(
        input logic              s,
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] m
    );
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fp8_mant_div.sv
// Restoring mantissa divider: one quotient bit per step.
// Produces floor(ma * 2^(QBITS-1) / mb) after QBITS steps.
module fp8_mant_div
    import fp8_pkg::*;
#(
    parameter int QBITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [MA_W-1:0]  ma,
    input  logic [MA_W-1:0]  mb,
    output logic [QBITS-1:0] q,
    output logic             last
);

    logic [REM_W-1:0] rem_q, rem_d;
    logic [MA_W-1:0]  mb_q, mb_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MA_W-1:0]  diff;
    logic             ge;

    // Trial subtract; rem < 2*mb so the low bits of the difference suffice.
    always_comb begin
        ge   = (rem_q >= {1'b0, mb_q});
        diff = rem_q[MA_W-1:0] - mb_q;
    end

    // Next-state for remainder, quotient and step counter.
    // The counter runs one past QBITS so the caller gets a drain cycle.
    always_comb begin
        rem_d = rem_q;
        mb_d  = mb_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = {1'b0, ma};
            mb_d  = mb;
            q_d   = '0;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_W'(QBITS)) begin
                if (ge) begin
                    q_d   = {q_q[QBITS-2:0], 1'b1};
                    rem_d = {diff, 1'b0};
                end else begin
                    q_d   = {q_q[QBITS-2:0], 1'b0};
                    rem_d = {rem_q[MA_W-1:0], 1'b0};
                end
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            mb_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            mb_q  <= mb_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q    = q_q;
    assign last = (cnt_q == CNT_W'(QBITS));

endmodule

// File: rtl/fp8_divider.sv
// FP8 sequential divider: start/busy/done handshake around the
// restoring mantissa loop, with sign/exponent path and normaliser.
module fp8_divider #(
    parameter int EXP_BIAS = fp8_pkg::EXP_BIAS,
    parameter int QBITS    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] out
);

    import fp8_pkg::*;

    state_t state_q, state_d;
    logic   sign_q, sign_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic [7:0] out_q, out_d;
    logic signed [EDIFF_W-1:0] ediff_q, ediff_d;

    logic             load;
    logic             step;
    logic             last;
    logic [QBITS-1:0] q;

    logic signed [EDIFF_W-1:0] e_norm;
    logic [MANT_W-1:0]         mant;
    logic [7:0]                norm_res;

    fp8_mant_div #(
        .QBITS (QBITS)
    ) u_mant_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .ma    (fp8_mant(a)),
        .mb    (fp8_mant(b)),
        .q     (q),
        .last  (last)
    );

    // Normalise the quotient and clamp the exponent to the format range.
    always_comb begin
        if (q[QBITS-1]) begin
            mant   = q[QBITS-2 -: MANT_W];
            e_norm = ediff_q;
        end else begin
            mant   = q[QBITS-3 -: MANT_W];
            e_norm = ediff_q - 5'sd1;
        end
        if (e_norm > $signed(EDIFF_W'(EXP_MAX))) begin
            norm_res = {sign_q, FP8_SAT_MAG};
        end else if (e_norm[EDIFF_W-1]) begin
            norm_res = {sign_q, FP8_FLUSH_MAG};
        end else begin
            norm_res = fp8_pack(sign_q, e_norm[EXP_W-1:0], mant);
        end
    end

    // Control FSM next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ediff_d = ediff_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = a[SIGN_BIT] ^ b[SIGN_BIT];
                    ediff_d = $signed({2'b00, a[EXP_MSB:EXP_LSB]})
                            - $signed({2'b00, b[EXP_MSB:EXP_LSB]})
                            + $signed(EDIFF_W'(EXP_BIAS));
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (last) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                out_d   = norm_res;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers; reset abandons any divide in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ediff_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ediff_q <= ediff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule
